// File: rtl/adder_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_seq_pkg                                                |
// | Description : Shared opcodes, state encodings and control-word bit          |
// |               positions for the adder/accumulator control sequencer.       |
// |               The opcode 110 decode depends on ADDER_SEQ_CONDADD_EN in the  |
// |               decode block; this package is identical in both builds.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package adder_seq_pkg;

   // Opcodes (3-bit)
   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_LDA   = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_OUT   = 3'b100;
   localparam logic [2:0] OP_CLR   = 3'b101;
   localparam logic [2:0] OP_ADDNZ = 3'b110;
   localparam logic [2:0] OP_HLT   = 3'b111;

   // Sequencer states (3-bit)
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_LOADA = 3'd2,
      ST_LOADB = 3'd3,
      ST_EXEC  = 3'd4,
      ST_HALT  = 3'd5
   } state_t;

   // Control-word bit positions
   localparam int CW_LOAD_BUS = 0;
   localparam int CW_NLA      = 1;
   localparam int CW_NLB      = 2;
   localparam int CW_EU       = 3;
   localparam int CW_SUB      = 4;
   localparam int CW_OUT_SEL  = 5;
   localparam int CW_BUSY     = 6;
   localparam int CW_DONE     = 7;
   localparam int CW_ILLEGAL  = 8;
   localparam int CW_HALTED   = 9;
   localparam int CW_W        = 10;

   typedef logic [CW_W-1:0] cw_t;

   // Idle control word: everything inactive, active-low loads held high
   localparam cw_t CW_IDLE = cw_t'((1 << CW_NLA) | (1 << CW_NLB));

endpackage
`default_nettype wire

// File: rtl/adder_seq_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_seq_decode                                             |
// | Description : Combinational next-state and next-control-word decode.       |
// |               The word produced is the one the output registers hold while |
// |               the sequencer sits in the returned next state.               |
// | Ports       : state_i   current state                                      |
// |               accept_i  instruction handshake this cycle                   |
// |               op_i      incoming opcode on accept, else captured opcode    |
// |               imm_i     incoming immediate on accept, else captured imm    |
// |               zf_i      datapath zero flag (used only for ADDNZ)           |
// |               out_sel_i current output select (held unless OUT)            |
// |               state_o   next state                                         |
// |               cw_o      next control word                                  |
// |               data_o    next datapath input value                          |
// | Config      : ADDER_SEQ_CONDADD_EN enables opcode 110 as ADDNZ             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adder_seq_decode
   import adder_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
) (
   input  state_t            state_i,
   input  logic              accept_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic              zf_i,
   input  logic              out_sel_i,
   output state_t            state_o,
   output cw_t               cw_o,
   output logic [DATA_W-1:0] data_o
);

   logic is_load_a;
   logic is_clr;

   assign is_load_a = (op_i == OP_LDA) || (op_i == OP_CLR);
   assign is_clr    = (op_i == OP_CLR);

`ifndef ADDER_SEQ_CONDADD_EN
   // zf only matters for ADDNZ
   logic unused_zf;
   assign unused_zf = zf_i;
`endif

   always_comb begin
      state_o             = state_i;
      cw_o                = CW_IDLE;
      cw_o[CW_OUT_SEL]    = out_sel_i;
      data_o              = '0;

      case (state_i)
         ST_IDLE: begin
            if (accept_i) begin
               case (op_i)
                  OP_NOP: ;
                  OP_LDA, OP_CLR, OP_ADD, OP_SUB: state_o = ST_DRIVE;
                  OP_OUT: cw_o[CW_OUT_SEL] = imm_i[0];
                  OP_HLT: state_o = ST_HALT;
`ifdef ADDER_SEQ_CONDADD_EN
                  // zf set means nothing to add: behave as a silent NOP
                  OP_ADDNZ: if (!zf_i) state_o = ST_DRIVE;
`endif
                  default: cw_o[CW_ILLEGAL] = 1'b1;
               endcase
            end
         end
         ST_DRIVE: state_o = is_load_a ? ST_LOADA : ST_LOADB;
         ST_LOADA: state_o = ST_IDLE;
         ST_LOADB: state_o = ST_EXEC;
         ST_EXEC:  state_o = ST_IDLE;
         ST_HALT:  state_o = ST_HALT;
         default:  state_o = ST_IDLE;
      endcase

      // Moore decode of the state being entered
      case (state_o)
         ST_DRIVE: begin
            cw_o[CW_LOAD_BUS] = 1'b1;
            data_o            = is_clr ? '0 : imm_i;
         end
         ST_LOADA: begin
            cw_o[CW_LOAD_BUS] = 1'b1;
            cw_o[CW_NLA]      = 1'b0;
            data_o            = is_clr ? '0 : imm_i;
         end
         ST_LOADB: begin
            cw_o[CW_LOAD_BUS] = 1'b1;
            cw_o[CW_NLB]      = 1'b0;
            data_o            = imm_i;
         end
         ST_EXEC: begin
            cw_o[CW_EU]  = 1'b1;
            cw_o[CW_SUB] = (op_i == OP_SUB);
            cw_o[CW_NLA] = 1'b0;
         end
         ST_HALT: cw_o[CW_HALTED] = 1'b1;
         default: ;
      endcase

      cw_o[CW_BUSY] = (state_o != ST_IDLE);
      // Completion is flagged on the first idle cycle after the A write
      cw_o[CW_DONE] = (state_o == ST_IDLE) &&
                      ((state_i == ST_LOADA) || (state_i == ST_EXEC));
   end

endmodule
`default_nettype wire

// File: rtl/adder_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_sequencer                                              |
// | Description : Microcoded control sequencer for the adder/accumulator       |
// |               datapath. Expands one opcode+immediate per handshake into    |
// |               the multi-cycle control-word sequence; all outputs except    |
// |               instr_ready are registered.                                  |
// | Ports       : clk, rst (sync, active-high)                                 |
// |               instr_valid/instr_ready/instr_op/instr_imm  instruction in   |
// |               zf        datapath zero flag, sampled at accept              |
// |               data_out  datapath input value                               |
// |               load_bus, nla, nlb, ea, eu, sub, out_sel  control word       |
// |               busy, done, illegal, halted  status                          |
// | Config      : ADDER_SEQ_CONDADD_EN enables opcode 110 as ADDNZ             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adder_sequencer
   import adder_seq_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [OP_W-1:0]   instr_op,
   input  logic [DATA_W-1:0] instr_imm,
   input  logic              zf,
   output logic [DATA_W-1:0] data_out,
   output logic              load_bus,
   output logic              nla,
   output logic              nlb,
   output logic              ea,
   output logic              eu,
   output logic              sub,
   output logic              out_sel,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic              halted
);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_eff;
   logic [DATA_W-1:0] imm_q, imm_eff;
   logic [DATA_W-1:0] data_q, data_d;
   cw_t               cw_q, cw_d;
   logic              accept;

   assign instr_ready = (state_q == ST_IDLE) && !rst;
   assign accept      = instr_valid && instr_ready;

   // On accept the decode must see the incoming instruction, since the
   // first control word is registered on the same edge as the capture.
   assign op_eff  = accept ? instr_op  : op_q;
   assign imm_eff = accept ? instr_imm : imm_q;

   adder_seq_decode #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_decode (
      .state_i   (state_q),
      .accept_i  (accept),
      .op_i      (op_eff),
      .imm_i     (imm_eff),
      .zf_i      (zf),
      .out_sel_i (cw_q[CW_OUT_SEL]),
      .state_o   (state_d),
      .cw_o      (cw_d),
      .data_o    (data_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         imm_q   <= '0;
         data_q  <= '0;
         cw_q    <= CW_IDLE;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cw_q    <= cw_d;
         if (accept) begin
            op_q  <= instr_op;
            imm_q <= instr_imm;
         end
      end
   end

   assign data_out = data_q;
   assign load_bus = cw_q[CW_LOAD_BUS];
   assign nla      = cw_q[CW_NLA];
   assign nlb      = cw_q[CW_NLB];
   assign ea       = 1'b0;
   assign eu       = cw_q[CW_EU];
   assign sub      = cw_q[CW_SUB];
   assign out_sel  = cw_q[CW_OUT_SEL];
   assign busy     = cw_q[CW_BUSY];
   assign done     = cw_q[CW_DONE];
   assign illegal  = cw_q[CW_ILLEGAL];
   assign halted   = cw_q[CW_HALTED];

endmodule
`default_nettype wire

// File: doc/adder_sequencer.md
Name: adder_sequencer

Overview:
- Microcoded control sequencer that sits directly upstream of the adder/accumulator datapath.
- Accepts one instruction per handshake: a 3-bit opcode plus an 8-bit immediate.
- Expands each instruction into the multi-cycle control-word sequence the datapath needs: input-buffer load, B load, ALU enable/subtract, A load and output select.
- Places the immediate on the datapath input port.

Parameters:
- DATA_W, 8, immediate/operand width; equals the datapath bus width.
- OP_W, 3, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  OP_W  opcode.
- instr_imm  in  DATA_W  immediate operand.
- zf  in  1  zero flag from the datapath ALU.
- data_out  out  DATA_W  drives the datapath ui_in.
- load_bus  out  1  datapath input-buffer enable / bus drive.
- nla  out  1  active-low load of A.
- nlb  out  1  active-low load of B.
- ea  out  1  A bus enable; tied low by this block, kept for bus compatibility.
- eu  out  1  ALU result enable.
- sub  out  1  ALU subtract select.
- out_sel  out  1  1 = show bus on output pins, 0 = show A.
- busy  out  1  multi-cycle instruction in progress or halted.
- done  out  1  one-cycle pulse when a multi-cycle instruction completes.
- illegal  out  1  one-cycle pulse on acceptance of an undefined opcode.
- halted  out  1  HLT executed.

Behaviour:
- Accept on rising clk when instr_valid && instr_ready. instr_ready = (state == IDLE) && !rst. op and imm are captured into registers on accept.
- All outputs are registered (Moore decode of the state register plus the captured imm). Values given below are what the outputs hold during each state.
- Reset and idle values: data_out=0, load_bus=0, nla=1, nlb=1, ea=0, eu=0, sub=0, out_sel=0, busy=0, done=0, illegal=0, halted=0; state=IDLE.
- Opcodes:
  - 000 NOP
  - 001 LDA
  - 010 ADD
  - 011 SUB
  - 100 OUT
  - 101 CLR
  - 110 reserved (see Optional Feature)
  - 111 HLT
- States: IDLE, DRIVE, LOADA, LOADB, EXEC, HALT.
- NOP / OUT / illegal:
  - Stay in IDLE; instr_ready stays high, so back-to-back accepts are allowed every cycle.
  - OUT sets out_sel <= imm[0]; out_sel persists until the next OUT or reset.
  - Illegal opcode pulses illegal for 1 cycle, otherwise NOP.
- LDA: IDLE -> DRIVE -> LOADA -> IDLE.
  - DRIVE: load_bus=1, data_out=imm.
  - LOADA: load_bus=1, data_out=imm, nla=0.
  - done pulses in the first IDLE cycle after LOADA.
  - Latency: 2 cycles from accept to the A write edge.
- CLR: identical to LDA with data_out forced to 0.
- ADD / SUB: IDLE -> DRIVE -> LOADB -> EXEC -> IDLE.
  - DRIVE: load_bus=1, data_out=imm.
  - LOADB: load_bus=1, data_out=imm, nlb=0.
  - EXEC: load_bus=0, data_out=0, eu=1, sub=(op==SUB), nla=0.
  - done pulses after EXEC.
  - Latency: 3 cycles.
- HLT: IDLE -> HALT. Outputs at idle values except busy=1 and halted=1. instr_ready=0. Only rst leaves HALT.
- busy=1 in every state except IDLE.
- zf is sampled only in IDLE, at accept time.
- Reset mid-instruction: on the rst edge, state returns to IDLE and all outputs take reset values on the next cycle. No partial done is issued. The captured op is discarded.
- instr_valid low or X while ready is high: no state change. instr_op/imm are ignored unless an accept occurs.
- Arithmetic is performed in the datapath; the sequencer does no width extension and passes imm unmodified.

Optional Feature:
- Macro: ADDER_SEQ_CONDADD_EN.
- Defined: opcode 110 = ADDNZ.
  - If zf==0 at accept, runs the exact ADD sequence.
  - If zf==1, behaves as NOP: stays IDLE, no done, no illegal.
- Undefined: opcode 110 is illegal (NOP + illegal pulse); zf is unused.

Decomposition:
- Package adder_seq_pkg holds:
  - opcode localparams OP_NOP..OP_HLT (3-bit);
  - state encodings ST_IDLE..ST_HALT (3-bit);
  - the control-word bit positions.
- One sub-module is natural: adder_seq_decode, a purely combinational map of (state, op, imm) to the next control word. The top holds the state, the captured op/imm and the output registers.

Test Plan:
1. Reset, then LDA imm=0x2A → 2 cycles later, one cycle each of load_bus=1/data_out=0x2A, then nla=0. done pulses once. instr_ready low for exactly 2 cycles.
2. LDA 0x05, then SUB 0x05 → EXEC cycle shows eu=1, sub=1, nla=0, load_bus=0. Total SUB latency 3 cycles. Datapath zf=1 afterwards.
3. Back-to-back NOP, OUT imm=1, OUT imm=0 with instr_valid held high → accepted on 3 consecutive cycles. out_sel reads 1 then 0. busy stays 0.
4. ADD 0x10 with rst asserted during LOADB → next cycle all outputs at reset values, state IDLE, no done pulse.
5. HLT, then instr_valid=1 for 10 cycles → instr_ready=0 and halted=1 throughout. rst clears halted.
6. Opcode 110 with zf=1, then with zf=0 → macro defined: NOP, then a full ADD sequence. Macro undefined: illegal pulses both times.
